// File: rtl/key_schedule_encr.sv
// AES-128 encryption key schedule: produces round keys 0..10 one at a time,
// advancing on each consumer acknowledge.
//
// state  | meaning
// IDLE   | no schedule in progress, waiting for key_load
// ACTIVE | round_key/round_idx valid, advancing on key_next
module key_schedule_encr (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_load,
  input  logic         key_next,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         key_valid,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so ~a selects the byte offset from bit 0.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] ia;
    ia = ~a;
    return SBOX_TABLE[{ia, 3'b000} +: 8];
  endfunction

  state_t      state;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, t;
  logic [31:0] n0, n1, n2, n3;
  logic [3:0]  idx_next;
  logic [7:0]  rcon;

  assign {w0, w1, w2, w3} = round_key;
  assign idx_next = round_idx + 4'd1;
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign sub[8*i +: 8] = sbox(rot[8*i +: 8]);
  end

  always_comb begin
    rcon = 8'h00;
    case (idx_next)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t  = sub ^ {rcon, 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      round_key <= '0;
      round_idx <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (key_load) begin
            round_key <= key_in;
            round_idx <= 4'd0;
            key_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= ACTIVE;
          end
        end
        ACTIVE: begin
          // A reload wins over an acknowledge, including on the final round.
          if (key_load) begin
            round_key <= key_in;
            round_idx <= 4'd0;
            key_valid <= 1'b1;
            busy      <= 1'b1;
          end else if (key_next) begin
            if (round_idx == 4'd10) begin
              key_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              round_key <= {n0, n1, n2, n3};
              round_idx <= idx_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_schedule_encr.sv
// Scoreboard bench for key_schedule_encr: an independent model (S-box derived
// from GF(2^8) inversion) queues expected outputs, popped after each edge.
module tb_key_schedule_encr;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_load;
  logic         key_next;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         busy;
  logic         done;

  key_schedule_encr dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_load  (key_load),
    .key_next  (key_next),
    .round_key (round_key),
    .round_idx (round_idx),
    .key_valid (key_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] key;
    logic [3:0]   idx;
    logic         valid;
    logic         busy;
    logic         done;
  } obs_t;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

  obs_t       exp_q[$];
  int         n_vec  = 0;
  int         n_miss = 0;
  logic [7:0] sb[256];

  logic         m_active;
  obs_t         m;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic void build_sbox();
    logic [7:0] inv, v;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++) begin
        v = x[7:0];
        if (a != 0 && gmul(a[7:0], v) == 8'h01) inv = v;
      end
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [127:0] mdl_next(input logic [127:0] k, input int rnd);
    logic [31:0] w[4];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    t = {sb[w[3][23:16]], sb[w[3][15:8]], sb[w[3][7:0]], sb[w[3][31:24]]};
    rc = 8'h01;
    for (int i = 1; i < rnd; i++) rc = xtime(rc);
    t[31:24] = t[31:24] ^ rc;
    w[0] = w[0] ^ t;
    w[1] = w[1] ^ w[0];
    w[2] = w[2] ^ w[1];
    w[3] = w[3] ^ w[2];
    return {w[0], w[1], w[2], w[3]};
  endfunction

  function automatic obs_t observed();
    return {round_key, round_idx, key_valid, busy, done};
  endfunction

  task automatic mdl_reset();
    m_active = 1'b0;
    m = '0;
  endtask

  // Drive one cycle of stimulus, advance the model and queue its expectation.
  task automatic drive(input logic ld, input logic nx, input logic [127:0] k);
    key_load = ld;
    key_next = nx;
    key_in   = k;
    m.done   = 1'b0;
    if (ld) begin
      m.key = k; m.idx = 4'd0; m.valid = 1'b1; m.busy = 1'b1; m_active = 1'b1;
    end else if (m_active && nx) begin
      if (m.idx == 4'd10) begin
        m.valid = 1'b0; m.busy = 1'b0; m.done = 1'b1; m_active = 1'b0;
      end else begin
        m.key = mdl_next(m.key, int'(m.idx) + 1);
        m.idx = m.idx + 4'd1;
      end
    end
    exp_q.push_back(m);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e;
    rst = 1'b1; key_load = 1'b0; key_next = 1'b0; key_in = '0;
    mdl_reset();
    #1;
    n_vec++;
    if (observed() !== obs_t'('0)) begin
      n_miss++;
      $display("FAIL reset_state: got %h want 0", observed());
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, i[0] == 1'b0, 128'hdeadbeef);
      e = exp_q.pop_front();
      n_vec++;
      if (observed() !== e) begin
        n_miss++;
        $display("FAIL reset_hold cyc %0d: got %h want %h", i, observed(), e);
      end
    end
  endtask

  task automatic test_fips_walk();
    obs_t e;
    int   n_done = 0;
    drive(1'b1, 1'b0, FIPS_KEY);
    e = exp_q.pop_front();
    n_vec++;
    if (observed() !== e) begin
      n_miss++;
      $display("FAIL fips_load: got %h want %h", observed(), e);
    end
    n_vec++;
    if (round_key !== FIPS_KEY || round_idx !== 4'd0 || key_valid !== 1'b1) begin
      n_miss++;
      $display("FAIL fips_r0: got %h/%0d/%b want %h/0/1", round_key, round_idx, key_valid, FIPS_KEY);
    end
    for (int r = 1; r <= 12; r++) begin
      drive(1'b0, 1'b1, '0);
      e = exp_q.pop_front();
      n_vec++;
      if (observed() !== e) begin
        n_miss++;
        $display("FAIL fips_walk step %0d: got %h want %h", r, observed(), e);
      end
      if (done === 1'b1) n_done++;
      if (r == 1) begin
        n_vec++;
        if (round_key !== FIPS_R1 || round_idx !== 4'd1) begin
          n_miss++;
          $display("FAIL fips_r1: got %h/%0d want %h/1", round_key, round_idx, FIPS_R1);
        end
      end
      if (r == 10) begin
        n_vec++;
        if (round_key !== FIPS_R10 || round_idx !== 4'd10 || done !== 1'b0) begin
          n_miss++;
          $display("FAIL fips_r10: got %h/%0d/%b want %h/10/0", round_key, round_idx, done, FIPS_R10);
        end
      end
      if (r == 11) begin
        n_vec++;
        if (done !== 1'b1 || key_valid !== 1'b0 || busy !== 1'b0 || round_key !== FIPS_R10) begin
          n_miss++;
          $display("FAIL fips_done: got done=%b valid=%b busy=%b key=%h want 1/0/0/%h",
                   done, key_valid, busy, round_key, FIPS_R10);
        end
      end
    end
    n_vec++;
    if (n_done != 1) begin
      n_miss++;
      $display("FAIL fips_done_count: got %0d want 1", n_done);
    end
  endtask

  task automatic test_zero_stall();
    obs_t e;
    drive(1'b1, 1'b0, '0);
    e = exp_q.pop_front();
    n_vec++;
    if (observed() !== e) begin
      n_miss++;
      $display("FAIL zero_load: got %h want %h", observed(), e);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 128'h5555);
      e = exp_q.pop_front();
      n_vec++;
      if (observed() !== e) begin
        n_miss++;
        $display("FAIL zero_stall cyc %0d: got %h want %h", i, observed(), e);
      end
    end
    drive(1'b0, 1'b1, '0);
    e = exp_q.pop_front();
    n_vec++;
    if (observed() !== e || round_key !== ZERO_R1 || round_idx !== 4'd1) begin
      n_miss++;
      $display("FAIL zero_r1: got %h/%0d want %h/1", round_key, round_idx, ZERO_R1);
    end
  endtask

  task automatic test_restart();
    obs_t         e;
    logic [127:0] k;
    for (int pass = 0; pass < 2; pass++) begin
      // pass 0 reloads at round 4, pass 1 reloads on the final acknowledge
      k = {$urandom, $urandom, $urandom, $urandom};
      drive(1'b1, 1'b0, k);
      void'(exp_q.pop_front());
      for (int r = 0; r < (pass == 0 ? 4 : 10); r++) begin
        drive(1'b0, 1'b1, '0);
        e = exp_q.pop_front();
        n_vec++;
        if (observed() !== e) begin
          n_miss++;
          $display("FAIL restart%0d walk r%0d: got %h want %h", pass, r + 1, observed(), e);
        end
      end
      k = {$urandom, $urandom, $urandom, $urandom};
      drive(1'b1, 1'b1, k);
      e = exp_q.pop_front();
      n_vec++;
      if (observed() !== e || round_key !== k || round_idx !== 4'd0 || done !== 1'b0) begin
        n_miss++;
        $display("FAIL restart%0d reload: got %h want %h", pass, observed(), e);
      end
      for (int r = 0; r < 3; r++) begin
        drive(1'b0, r != 1, '0);
        e = exp_q.pop_front();
        n_vec++;
        if (observed() !== e) begin
          n_miss++;
          $display("FAIL restart%0d after r%0d: got %h want %h", pass, r, observed(), e);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t e;
    drive(1'b1, 1'b0, FIPS_KEY);
    void'(exp_q.pop_front());
    for (int r = 0; r < 7; r++) begin
      drive(1'b0, 1'b1, '0);
      e = exp_q.pop_front();
      n_vec++;
      if (observed() !== e) begin
        n_miss++;
        $display("FAIL areset walk r%0d: got %h want %h", r + 1, observed(), e);
      end
    end
    key_next = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mdl_reset();
    #1;
    n_vec++;
    if (observed() !== obs_t'('0)) begin
      n_miss++;
      $display("FAIL areset_immediate: got %h want 0", observed());
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, FIPS_KEY);
      e = exp_q.pop_front();
      n_vec++;
      if (observed() !== e) begin
        n_miss++;
        $display("FAIL areset_after cyc %0d: got %h want %h", i, observed(), e);
      end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_walk();
    test_zero_stall();
    test_restart();
    test_async_reset();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/key_schedule_encr.md
KEY_SCHEDULE_ENCR -- requirements
Module: key_schedule_encr

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the ports SHALL be:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- key_in  input  128  AES-128 cipher key; byte 0 in bits [127:120]
- key_load  input  1  single-cycle strobe that captures key_in and starts a schedule
- key_next  input  1  consumer acknowledge that the presented round key has been used
- round_key  output  128  current round key, for the add-round-key stage
- round_idx  output  4  index of round_key, 0..10
- key_valid  output  1  round_key/round_idx are valid
- busy  output  1  a schedule is in progress
- done  output  1  one-cycle pulse after round key 10 is acknowledged

REQ-002 The block SHALL have no parameters; the key size is fixed at 128 bits and the round count at 10.

Function
REQ-003 The FSM SHALL have exactly two states: IDLE and ACTIVE.
REQ-004 In IDLE, key_load=1 SHALL, on that edge, set round_key=key_in, round_idx=0, key_valid=1, busy=1, and state=ACTIVE. The key is therefore visible on the cycle after the load.
REQ-005 In ACTIVE, key_next=1 with round_idx<10 SHALL, on that edge, replace round_key with the next FIPS-197 round key and increment round_idx. Latency is one cycle per round key, and key_valid SHALL stay 1.
REQ-006 The next round key SHALL be computed combinationally from round_key:
- t = SubWord(RotWord(w3)) XOR {rcon,24'h0}
- w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'
- w0 is bits [127:96] and w3 is bits [31:0].
REQ-007 rcon SHALL be selected by the next index 1..10 as 01,02,04,08,10,20,40,80,1b,36. The S-box SHALL be the standard AES forward S-box, with four instances.
REQ-008 With key_next=0, round_key and round_idx SHALL hold indefinitely.
REQ-009 In ACTIVE, key_next=1 with round_idx=10 SHALL, on that edge:
- set key_valid=0 and busy=0;
- pulse done=1 for exactly one cycle;
- set state=IDLE.
round_key and round_idx SHALL retain their last values.
REQ-010 key_load=1 in ACTIVE SHALL restart exactly as in REQ-004, and SHALL take priority over a simultaneous key_next.
REQ-011 key_load=1 on the same edge that REQ-009 completes SHALL restart, with done remaining 0.
REQ-012 key_next in IDLE SHALL be ignored.
REQ-013 done SHALL never be 1 on two consecutive cycles.
REQ-014 All outputs SHALL be driven directly from registers.

Reset
REQ-015 rst=1 SHALL immediately, without waiting for a clock edge, force:
- state=IDLE
- round_key=0
- round_idx=0
- key_valid=0, busy=0, done=0
REQ-016 The outputs SHALL stay at the values in REQ-015 until the first key_load after rst is released.
REQ-017 rst asserted mid-schedule SHALL abandon the schedule; no done pulse SHALL be produced.

Verification
REQ-018 FIPS-197 load: key_in=2b7e151628aed2a6abf7158809cf4f3c with key_load pulsed -> next cycle round_idx=0, round_key=2b7e151628aed2a6abf7158809cf4f3c, key_valid=1.
REQ-019 Full walk: key_next held high from round 0 -> the bench SHALL check:
- round 1 = a0fafe1788542cb123a339392a6c7605
- round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
- done pulses once, one cycle after round 10 is acknowledged, with key_valid=0 on the same cycle.
REQ-020 Zero key, stalled: key_in=0 is loaded, then key_next is held low for 5 cycles -> round_key=0 and round_idx=0 are held. One key_next pulse -> round 1 = 62636363626363636263636362636363.
REQ-021 Restart: key_load is pulsed together with key_next at round_idx=4 -> next cycle round_idx=0 with the new key, and no done pulse.
REQ-022 Async reset: rst is asserted between clock edges at round_idx=7 -> all outputs are 0 before the next edge. A key_next after reset release -> no change.
